// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter and receiver FSM states, default baud
// divider and the 7-segment digit codes used by the display path.
package uart_pkg;

   localparam int DEFAULT_DELAY_FRAMES = 234;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_START = 3'd1,
      RX_READ  = 3'd2,
      RX_WAIT  = 3'd3,
      RX_DONE  = 3'd4
   } rx_state_t;

   // Segment order {g,f,e,d,c,b,a}, active high.
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   function automatic logic [6:0] seg_digit(input logic [3:0] digit);
      logic [6:0] seg;
      unique case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count and a combinational head
// on rdata_o; pushes while full and pops while empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_tx_stream.sv
// Buffered 8N1 UART transmitter: bytes queue in a small FIFO and leave LSB first
// back-to-back; the line is a flop that lags the FSM state by one cycle.
module uart_tx_stream
   import uart_pkg::*;
#(
   parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic       uart_tx_o,
   output logic       busy_o
);

   localparam int BAUD_W = $clog2(DELAY_FRAMES);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DELAY_FRAMES - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

   tx_state_t         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              busy_q;

   logic              fifo_push, fifo_pop;
   logic [7:0]        fifo_rdata;
   logic              fifo_full, fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic              baud_last;

   // Ready is masked during reset so nothing is accepted while the queue is flushed.
   assign tx_ready_o = !fifo_full && !reset_i;
   assign fifo_push  = tx_valid_i && tx_ready_o;
   assign baud_last  = (baud_q == BAUD_LAST);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i (tx_data_i),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rdata;
               bit_d    = '0;
               baud_d   = '0;
               state_d  = START;
            end
         end
         START: begin
            if (baud_last) begin
               baud_d  = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
         DATA: begin
            if (baud_last) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
         STOP: begin
            if (baud_last) begin
               baud_d = '0;
               // Chain straight into the next start bit when more bytes are waiting.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_rdata;
                  bit_d    = '0;
                  state_d  = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
      endcase
   end

   always_comb begin
      tx_d = 1'b1;
      unique case (state_q)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_q[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         // Registered alongside the line so busy falls right after the stop bit leaves.
         busy_q  <= (state_q != IDLE) || (fifo_count != '0);
      end
   end

   assign uart_tx_o = tx_q;
   assign busy_o    = busy_q;

endmodule
